// File: rtl/mem_access_unit_if.sv
// Data-memory bus: registered request channel (req/ready) plus read response (rvalid/rdata).
// Build option: none.
//   master: drives dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe; samples dmemReady, dmemRvalid, dmemRdata
//   slave : the memory side of the same signals
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) ();
  logic              dmemReq;
  logic              dmemWe;
  logic [ADDR_W-1:0] dmemAddr;
  logic [XLEN-1:0]   dmemWdata;
  logic [3:0]        dmemBe;
  logic              dmemReady;
  logic              dmemRvalid;
  logic [XLEN-1:0]   dmemRdata;

  modport master (
    output dmemReq, dmemWe, dmemAddr,
    output dmemWdata, dmemBe,
    input  dmemReady, dmemRvalid, dmemRdata
  );

  modport slave (
    input  dmemReq, dmemWe, dmemAddr,
    input  dmemWdata, dmemBe,
    output dmemReady, dmemRvalid, dmemRdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: lane/byte-enable generation, load align/extend, pipeline stall.
// Build option: MISALIGN_TRAP_EN turns misaligned LH/LHU/SH/LW/SW into a bus-less trap.
//   clk, rst_n          : clock, async active-low reset
//   memWrite_MEM        : store in MEM
//   resultSrc_MEM       : 2'b01 = load in MEM
//   funct3_MEM          : access size/sign code
//   ALUResult_MEM       : effective byte address
//   storeOut_MEM        : store source value
//   dmem                : data-memory bus (master side)
//   stall_MEM           : hold the front of the pipeline
//   readData_MEM        : aligned, extended load result
//   misaligned_MEM      : misaligned-access flag, one DONE cycle
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            memWrite_MEM,
  input  logic [1:0]      resultSrc_MEM,
  input  logic [2:0]      funct3_MEM,
  input  logic [31:0]     ALUResult_MEM,
  input  logic [XLEN-1:0] storeOut_MEM,
  mem_access_unit_if.master dmem,
  output logic            stall_MEM,
  output logic [XLEN-1:0] readData_MEM,
  output logic            misaligned_MEM
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_nxt;

  logic              r_req, w_req;
  logic              r_we, w_we;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [XLEN-1:0]   r_wdata, w_wdata;
  logic [3:0]        r_be, w_be;
  logic [XLEN-1:0]   r_rd, w_rd;
  logic              r_mis, w_mis;
  logic [1:0]        r_off, w_off;
  logic [2:0]        r_f3, w_f3;
  logic              r_ld, w_ld;

  logic              w_access;
  logic              w_trap;
  logic [1:0]        w_a;
  logic [3:0]        w_lane_be;
  logic [XLEN-1:0]   w_lane_wd;

  assign w_a      = ALUResult_MEM[1:0];
  assign w_access = memWrite_MEM
                  | (resultSrc_MEM == 2'b01);

`ifdef MISALIGN_TRAP_EN
  assign w_trap =
    ((funct3_MEM[1:0] == 2'b01) & w_a[0])
    | ((funct3_MEM[1:0] == 2'b10)
       & (w_a != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  always_comb begin
    w_lane_be = 4'b1111;
    w_lane_wd = storeOut_MEM;
    unique case (funct3_MEM[1:0])
      2'b00: begin
        w_lane_be = 4'b0001 << w_a;
        w_lane_wd = {4{storeOut_MEM[7:0]}};
      end
      2'b01: begin
        w_lane_be = w_a[1] ? 4'b1100 : 4'b0011;
        w_lane_wd = {2{storeOut_MEM[15:0]}};
      end
      default: begin
        w_lane_be = 4'b1111;
        w_lane_wd = storeOut_MEM;
      end
    endcase
  end

  // Offset and size come from the request-time copies.
  function automatic logic [XLEN-1:0] f_ext(
    input logic [2:0]      f3,
    input logic [1:0]      off,
    input logic [XLEN-1:0] w
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] res;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    unique case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'd0, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'd0, h};
      default: res = w;
    endcase
    return res;
  endfunction

  always_comb begin
    w_nxt   = r_state;
    w_req   = r_req;
    w_we    = r_we;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_be    = r_be;
    w_rd    = r_rd;
    w_mis   = 1'b0;
    w_off   = r_off;
    w_f3    = r_f3;
    w_ld    = r_ld;
    unique case (r_state)
      IDLE: begin
        if (w_access) begin
          if (w_trap) begin
            w_nxt = DONE;
            w_mis = 1'b1;
            w_rd  = '0;
          end else begin
            w_nxt   = REQ;
            w_req   = 1'b1;
            w_we    = memWrite_MEM;
            w_addr  = {ALUResult_MEM[ADDR_W-1:2], 2'b00};
            w_be    = memWrite_MEM ? w_lane_be : 4'b1111;
            w_wdata = w_lane_wd;
            w_off   = w_a;
            w_f3    = funct3_MEM;
            w_ld    = ~memWrite_MEM;
          end
        end
      end
      REQ: begin
        if (dmem.dmemReady) begin
          w_req = 1'b0;
          if (!r_ld) begin
            w_nxt = DONE;
          end else if (dmem.dmemRvalid) begin
            w_rd  = f_ext(r_f3, r_off, dmem.dmemRdata);
            w_nxt = DONE;
          end else begin
            w_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem.dmemRvalid) begin
          w_rd  = f_ext(r_f3, r_off, dmem.dmemRdata);
          w_nxt = DONE;
        end
      end
      DONE: w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= 4'b0000;
      r_rd    <= '0;
      r_mis   <= 1'b0;
      r_off   <= 2'b00;
      r_f3    <= 3'b000;
      r_ld    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_req   <= w_req;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_be    <= w_be;
      r_rd    <= w_rd;
      r_mis   <= w_mis;
      r_off   <= w_off;
      r_f3    <= w_f3;
      r_ld    <= w_ld;
    end
  end

  assign dmem.dmemReq   = r_req;
  assign dmem.dmemWe    = r_we;
  assign dmem.dmemAddr  = r_addr;
  assign dmem.dmemWdata = r_wdata;
  assign dmem.dmemBe    = r_be;

  // Low in DONE so exactly one instruction advances; forced low in reset.
  assign stall_MEM      = rst_n & w_access
                        & (r_state != DONE);
  assign readData_MEM   = r_rd;
  assign misaligned_MEM = r_mis;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus multi-cycle corner sequences.
// Build option: MISALIGN_TRAP_EN selects the trap-mode misaligned checks.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memWrite;
  logic [1:0]  resultSrc;
  logic [2:0]  funct3;
  logic [31:0] alu;
  logic [31:0] sout;
  logic        stall;
  logic [31:0] rd;
  logic        mis;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .memWrite_MEM   (memWrite),
    .resultSrc_MEM  (resultSrc),
    .funct3_MEM     (funct3),
    .ALUResult_MEM  (alu),
    .storeOut_MEM   (sout),
    .dmem           (bus),
    .stall_MEM      (stall),
    .readData_MEM   (rd),
    .misaligned_MEM (mis)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] so;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    int          e_stall;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;
  int n_acc  = 0;
  int cfg_rdy_dly = 0;
  int cfg_rv_dly  = 0;
  int rv_left = 0;
  int req_cyc = 0;

  int          o_stall;
  logic        o_seen, o_stable, o_tmo;
  logic [31:0] o_addr, o_wd, o_rd;
  logic [3:0]  o_be;
  logic        o_we, o_mis;

  vec_t tv[11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  function automatic vec_t mk(
    input logic st, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] so,
    input logic [31:0] rdata, input logic [31:0] e_addr,
    input logic [3:0] e_be, input logic [31:0] e_wd,
    input logic [31:0] e_rd, input int e_stall);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.so = so;
    v.rdata = rdata; v.e_addr = e_addr; v.e_be = e_be;
    v.e_wd = e_wd; v.e_rd = e_rd; v.e_stall = e_stall;
    return v;
  endfunction

  // Memory model: ready after cfg_rdy_dly request cycles,
  // rvalid cfg_rv_dly cycles after ready (0 = same cycle).
  always begin
    @(posedge clk);
    #1;
    bus.dmemRvalid = 1'b0;
    if (rv_left > 0) begin
      rv_left--;
      if (rv_left == 0) bus.dmemRvalid = 1'b1;
    end
    if (bus.dmemReq && rst_n) begin
      bus.dmemReady = (req_cyc == cfg_rdy_dly);
      req_cyc++;
      if (bus.dmemReady && !bus.dmemWe) begin
        if (cfg_rv_dly == 0) bus.dmemRvalid = 1'b1;
        else rv_left = cfg_rv_dly;
      end
    end else begin
      bus.dmemReady = 1'b0;
      req_cyc = 0;
    end
  end

  always @(posedge clk)
    if (bus.dmemReq && bus.dmemReady) n_acc++;

  task automatic do_access(input logic st,
                           input logic [2:0] f3,
                           input logic [31:0] addr,
                           input logic [31:0] so);
    @(posedge clk);
    #1;
    memWrite  = st;
    resultSrc = st ? 2'b00 : 2'b01;
    funct3    = f3;
    alu       = addr;
    sout      = so;
    o_stall = 0; o_seen = 0; o_stable = 1; o_tmo = 1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.dmemReq) begin
        if (!o_seen) begin
          o_seen = 1;
          o_addr = bus.dmemAddr; o_be = bus.dmemBe;
          o_wd = bus.dmemWdata; o_we = bus.dmemWe;
        end else if ({o_addr, o_be, o_wd, o_we} !==
                     {bus.dmemAddr, bus.dmemBe,
                      bus.dmemWdata, bus.dmemWe}) begin
          o_stable = 0;
        end
      end
      if (!stall) begin
        o_tmo = 0; o_rd = rd; o_mis = mis;
        break;
      end
      o_stall++;
    end
    if (o_tmo) begin
      n_tot++;
      $display("FAIL timeout: stall_MEM still %b after 60 cycles",
               stall);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    memWrite = 1'b0;
    resultSrc = 2'b00;
  endtask

  int n0;

  initial begin
    rst_n = 1'b0;
    memWrite = 1'b0; resultSrc = 2'b00; funct3 = 3'b000;
    alu = '0; sout = '0;
    bus.dmemReady = 1'b0; bus.dmemRvalid = 1'b0;
    bus.dmemRdata = '0;

    tv[0]  = mk(1, 3'b000, 32'h1003, 32'h000000AB, 32'h0,
                32'h1000, 4'b1000, 32'hABABABAB, 32'h0, 2);
    tv[1]  = mk(1, 3'b001, 32'h1002, 32'h12345678, 32'h0,
                32'h1000, 4'b1100, 32'h56785678, 32'h0, 2);
    tv[2]  = mk(1, 3'b010, 32'h1004, 32'hCAFEBABE, 32'h0,
                32'h1004, 4'b1111, 32'hCAFEBABE, 32'h0, 2);
    tv[3]  = mk(1, 3'b000, 32'h1001, 32'h00000011, 32'h0,
                32'h1000, 4'b0010, 32'h11111111, 32'h0, 2);
    tv[4]  = mk(0, 3'b000, 32'h2001, 32'h0, 32'h000080FF,
                32'h2000, 4'b1111, 32'h0, 32'hFFFFFF80, 2);
    tv[5]  = mk(0, 3'b100, 32'h2003, 32'h0, 32'h9A000000,
                32'h2000, 4'b1111, 32'h0, 32'h0000009A, 2);
    tv[6]  = mk(0, 3'b001, 32'h2000, 32'h0, 32'h12348001,
                32'h2000, 4'b1111, 32'h0, 32'hFFFF8001, 2);
    tv[7]  = mk(0, 3'b101, 32'h2002, 32'h0, 32'hBEEF1234,
                32'h2000, 4'b1111, 32'h0, 32'h0000BEEF, 2);
    tv[8]  = mk(0, 3'b010, 32'h2008, 32'h0, 32'h01234567,
                32'h2008, 4'b1111, 32'h0, 32'h01234567, 2);
    tv[9]  = mk(0, 3'b011, 32'h200C, 32'h0, 32'hA5A5A5A5,
                32'h200C, 4'b1111, 32'h0, 32'hA5A5A5A5, 2);
    tv[10] = mk(1, 3'b010, 32'h1008, 32'h00000055, 32'h0,
                32'h1008, 4'b1111, 32'h00000055, 32'hA5A5A5A5, 2);

    #12;
    chk("rst_req", {31'd0, bus.dmemReq}, 32'd0);
    chk("rst_we", {31'd0, bus.dmemWe}, 32'd0);
    chk("rst_addr", bus.dmemAddr, 32'd0);
    chk("rst_wdata", bus.dmemWdata, 32'd0);
    chk("rst_be", {28'd0, bus.dmemBe}, 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_mis", {31'd0, mis}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      cfg_rdy_dly = 0; cfg_rv_dly = 0;
      bus.dmemRdata = tv[i].rdata;
      do_access(tv[i].st, tv[i].f3, tv[i].addr, tv[i].so);
      chk($sformatf("v%0d_addr", i), o_addr, tv[i].e_addr);
      chk($sformatf("v%0d_be", i), {28'd0, o_be},
          {28'd0, tv[i].e_be});
      chk($sformatf("v%0d_we", i), {31'd0, o_we},
          {31'd0, tv[i].st});
      if (tv[i].st)
        chk($sformatf("v%0d_wdata", i), o_wd, tv[i].e_wd);
      chk($sformatf("v%0d_stall", i), o_stall, tv[i].e_stall);
      chk($sformatf("v%0d_rd", i), o_rd, tv[i].e_rd);
      chk($sformatf("v%0d_mis", i), {31'd0, o_mis}, 32'd0);
      idle();
    end

    // LB, rvalid two cycles after ready
    cfg_rdy_dly = 0; cfg_rv_dly = 2;
    bus.dmemRdata = 32'h000080FF;
    do_access(0, 3'b000, 32'h2001, 32'h0);
    chk("lb_wait_stall", o_stall, 4);
    chk("lb_wait_rd", o_rd, 32'hFFFFFF80);
    idle();

    // LHU, ready held off three cycles
    cfg_rdy_dly = 3; cfg_rv_dly = 0;
    bus.dmemRdata = 32'hBEEF1234;
    do_access(0, 3'b101, 32'h2002, 32'h0);
    chk("lhu_stable", {31'd0, o_stable}, 32'd1);
    chk("lhu_addr", o_addr, 32'h2000);
    chk("lhu_stall", o_stall, 5);
    chk("lhu_rd", o_rd, 32'h0000BEEF);
    idle();

    // SW then LW back to back
    cfg_rdy_dly = 0; cfg_rv_dly = 0;
    bus.dmemRdata = 32'hDEADBEEF;
    n0 = n_acc;
    do_access(1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("b2b_sw_wdata", o_wd, 32'hDEADBEEF);
    chk("b2b_sw_stall", o_stall, 2);
    chk("b2b_sw_rd_kept", o_rd, 32'h0000BEEF);
    do_access(0, 3'b010, 32'h10, 32'h0);
    chk("b2b_lw_stall", o_stall, 2);
    chk("b2b_lw_rd", o_rd, 32'hDEADBEEF);
    idle();
    @(negedge clk);
    chk("b2b_nreq", n_acc - n0, 2);

    // Reset while a load sits in WAIT
    cfg_rdy_dly = 0; cfg_rv_dly = 4;
    bus.dmemRdata = 32'h11111111;
    @(posedge clk);
    #1;
    memWrite = 1'b0; resultSrc = 2'b01;
    funct3 = 3'b010; alu = 32'h3000;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_req", {31'd0, bus.dmemReq}, 32'd0);
    chk("rstw_stall", {31'd0, stall}, 32'd0);
    #1;
    resultSrc = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstw_rd_ignored", rd, 32'd0);
    chk("rstw_req_idle", {31'd0, bus.dmemReq}, 32'd0);
    cfg_rv_dly = 0;
    do_access(0, 3'b010, 32'h3000, 32'h0);
    chk("rstw_after_stall", o_stall, 2);
    chk("rstw_after_rd", o_rd, 32'h11111111);
    idle();

    // LW at a misaligned address
    cfg_rdy_dly = 0; cfg_rv_dly = 0;
    bus.dmemRdata = 32'hCAFEF00D;
    n0 = n_acc;
    do_access(0, 3'b010, 32'h2002, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_noreq", {31'd0, o_seen}, 32'd0);
    chk("mis_stall", o_stall, 1);
    chk("mis_flag", {31'd0, o_mis}, 32'd1);
    chk("mis_rd", o_rd, 32'd0);
    idle();
    @(negedge clk);
    chk("mis_flag_clr", {31'd0, mis}, 32'd0);
    chk("mis_nreq", n_acc - n0, 0);
`else
    chk("mis_addr", o_addr, 32'h2000);
    chk("mis_stall", o_stall, 2);
    chk("mis_flag", {31'd0, o_mis}, 32'd0);
    chk("mis_rd", o_rd, 32'hCAFEF00D);
    idle();
    @(negedge clk);
    chk("mis_nreq", n_acc - n0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store engine. Consumes the control and data signals leaving the EX/MEM pipeline register and drives the data-memory bus with a req/ready request channel and an rvalid response channel.
- Generates byte enables and store lane data, aligns and extends load data, and asserts stall_MEM so the front of the pipeline holds while an access is outstanding.
- Sits between the EX/MEM register and the MEM/WB register.

Parameters:
- ADDR_W, 32, bus address width; dmemAddr is always word-aligned.
- XLEN, 32, data width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- memWrite_MEM  in  1  store instruction in MEM
- resultSrc_MEM  in  2  2'b01 marks a load in MEM
- funct3_MEM  in  3  access size/sign code
- ALUResult_MEM  in  32  effective byte address
- storeOut_MEM  in  32  store source register value
- dmemReq  out  1  request valid (registered)
- dmemWe  out  1  1 = write, 0 = read (registered)
- dmemAddr  out  32  {ALUResult_MEM[31:2],2'b00} (registered)
- dmemWdata  out  32  lane-shifted store data (registered)
- dmemBe  out  4  byte enables (registered)
- dmemReady  in  1  bus accepts the request this cycle
- dmemRvalid  in  1  read data valid
- dmemRdata  in  32  raw read word
- stall_MEM  out  1  hold IF/ID/EX/MEM registers
- readData_MEM  out  32  aligned, extended load result
- misaligned_MEM  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Access is defined as memWrite_MEM | (resultSrc_MEM==2'b01). If both are set, the store takes priority.
- Reset (asynchronous, rst_n=0):
  - state=IDLE
  - dmemReq=0, dmemWe=0, dmemAddr=0, dmemWdata=0, dmemBe=0
  - readData_MEM=0, misaligned_MEM=0
  - A reset mid-transaction drops dmemReq immediately. A later rvalid is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: if access, register addr/we/be/wdata, set dmemReq=1 and go to REQ. Otherwise stay.
  - REQ: dmemReq and all request fields are held stable until dmemReady=1. On ready, dmemReq drops next cycle.
    - Store: go to DONE.
    - Load with dmemRvalid in the same cycle: capture data and go to DONE.
    - Load without rvalid: go to WAIT.
  - WAIT: on dmemRvalid, capture data and go to DONE. There is no timeout.
  - DONE: go to IDLE unconditionally.
- stall_MEM (combinational) = access & (state != DONE). It is low in DONE so the pipeline advances exactly one instruction.
  - A back-to-back access is seen in the IDLE cycle that follows DONE. No access is lost or repeated.
- Minimum latency with zero-wait ready/rvalid is 3 cycles per access (IDLE, REQ, DONE), i.e. 2 stall cycles.
- Store lanes, with a = ALUResult_MEM[1:0]:
  - funct3[1:0]=00 (SB): be=4'b0001<<a; wdata={4{storeOut[7:0]}}.
  - funct3[1:0]=01 (SH): be = a[1] ? 4'b1100 : 4'b0011; wdata={2{storeOut[15:0]}}.
  - Otherwise (SW): be=4'b1111; wdata=storeOut.
  - Loads drive be=4'b1111 and dmemWe=0.
- Load extraction uses the byte offset registered at request time, not the live input.
  - 000 LB: sign-extend byte a.
  - 100 LBU: zero-extend byte a.
  - 001 LH: sign-extend half a[1].
  - 101 LHU: zero-extend half a[1].
  - 010 and all other codes: full word.
- readData_MEM is registered at capture and holds its value until the next load capture. Stores do not modify it.
- dmemRvalid outside WAIT and outside REQ-with-load is ignored.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - In IDLE, an LH/LHU/SH with a[0]=1, or an LW/SW with a!=0, issues no bus request and goes directly to DONE.
  - misaligned_MEM=1 for that DONE cycle only. readData_MEM is set to 0.
- Undefined:
  - misaligned_MEM is tied to 0.
  - Address low bits beyond the lane selection are ignored: SH/LH use a[1] only; SW/LW ignore a.

Test Plan:
- Reset mid-WAIT: rst_n pulsed low while a load is in WAIT -> dmemReq=0 and stall_MEM=0 immediately; the state is IDLE after release.
- SB, zero-wait: addr 0x1003, storeOut=0x000000AB, ready=1 -> dmemAddr=0x1000, be=4'b1000, wdata=0xABABABAB; stall for 2 cycles.
- LB sign: addr 0x2001, rdata=0x0000_80FF, rvalid two cycles after ready -> readData_MEM=0xFFFFFF80; stall lasts 4 cycles.
- LHU, ready delayed 3 cycles: addr 0x2002, rdata=0xBEEF1234 -> request fields stable throughout REQ; readData_MEM=0x0000BEEF.
- Back-to-back: SW 0x10 of 0xDEADBEEF, then LW 0x10 echoing that data -> exactly two requests; readData_MEM=0xDEADBEEF.
- With MISALIGN_TRAP_EN: LW at 0x2002 -> no dmemReq; misaligned_MEM=1 for 1 cycle; stall for 1 cycle.
